// File: rtl/halfduplex_shifter_if.sv
// Command/response channels between the fabric and the half-duplex bit engine.
// master = fabric side, slave = engine side.
interface halfduplex_shifter_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_write, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/halfduplex_shifter.sv
// Half-duplex single-wire serializer/deserializer feeding a pad buffer; optional parity via HALFDUPLEX_PARITY_EN.
// Latency: write WIDTH*DIV+TURN+1 cycles to rsp_valid, read WIDTH*DIV+1 (each +DIV with parity).
// Backpressure: one command in flight; cmd_ready stays low until the response is taken with rsp_ready.
module halfduplex_shifter #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4,
  parameter int TURN  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  halfduplex_shifter_if.slave  bus,
  output logic                 pad_o,
  output logic                 pad_oe,
  input  logic                 pad_i,
  output logic                 busy
);

`ifdef HALFDUPLEX_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NB + 1);
  localparam int TW = $clog2(TURN + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(DIV / 2);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NB - 1);
  localparam logic [TW-1:0] TURN_LAST  = TW'(TURN - 1);

  typedef enum logic [2:0] {S_IDLE, S_TX, S_TURN, S_RX, S_RESP} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [TW-1:0]    tcnt;
  logic [WIDTH-1:0] word;
  // One spare LSB so the "next bit" tap sh[NB-1] exists even when NB is 1.
  logic [NB:0]      sh;
  logic [NB:0]      rx_nxt;
  logic [NB-1:0]    rx_fin;
  logic [NB-1:0]    tx_load;
  logic             rx_err;

  always_comb begin
    rx_nxt = {sh[NB-1:0], pad_i};
    // With DIV=2 the last sample lands on the same edge that closes the word.
    rx_fin = (cnt == CNT_SAMPLE) ? rx_nxt[NB-1:0] : sh[NB-1:0];
`ifdef HALFDUPLEX_PARITY_EN
    tx_load = {bus.cmd_data, ^bus.cmd_data};
    rx_err  = ^rx_fin;
`else
    tx_load = bus.cmd_data;
    rx_err  = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      idx           <= '0;
      tcnt          <= '0;
      word          <= '0;
      sh            <= '0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      pad_o         <= 1'b0;
      pad_oe        <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready <= 1'b0;
            busy          <= 1'b1;
            cnt           <= '0;
            idx           <= '0;
            word          <= bus.cmd_data;
            if (bus.cmd_write) begin
              state  <= S_TX;
              sh     <= {tx_load, 1'b0};
              pad_oe <= 1'b1;
              pad_o  <= tx_load[NB-1];
            end else begin
              state <= S_RX;
              sh    <= '0;
            end
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end

        S_TX: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              state  <= S_TURN;
              pad_oe <= 1'b0;
              pad_o  <= 1'b0;
              tcnt   <= '0;
            end else begin
              idx   <= idx + IW'(1);
              sh    <= sh << 1;
              pad_o <= sh[NB-1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_TURN: begin
          if (tcnt == TURN_LAST) begin
            state         <= S_RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= word;
            bus.rsp_err   <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        S_RX: begin
          if (cnt == CNT_SAMPLE) begin
            sh <= rx_nxt;
          end
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              state         <= S_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= rx_fin[NB-1 -: WIDTH];
              bus.rsp_err   <= rx_err;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_RESP: begin
          if (bus.rsp_ready) begin
            state         <= S_IDLE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.cmd_ready <= 1'b1;
            busy          <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_halfduplex_shifter.sv
// Bench for halfduplex_shifter: timeline model checked every cycle plus literal scenario expectations.
module tb_halfduplex_shifter;
  localparam int W    = 8;
  localparam int DIV  = 4;
  localparam int TURN = 2;
`ifdef HALFDUPLEX_PARITY_EN
  localparam int NB  = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = W;
  localparam bit PAR = 1'b0;
`endif
  localparam int PX = NB * DIV - W * DIV;

  logic clk = 1'b0;
  logic rst;
  logic pad_o, pad_oe, pad_i, busy;

  halfduplex_shifter_if #(.WIDTH(W)) bus ();

  halfduplex_shifter #(.WIDTH(W), .DIV(DIV), .TURN(TURN)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .pad_o  (pad_o),
    .pad_oe (pad_oe),
    .pad_i  (pad_i),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NB-1:0] frame(input logic [W-1:0] d);
    logic [NB-1:0] f;
`ifdef HALFDUPLEX_PARITY_EN
    f = {d, ^d};
`else
    f = d;
`endif
    return f;
  endfunction

  // Model: position in the command timeline, counted from the acceptance edge.
  bit            m_act   = 1'b0;
  bit            m_ready = 1'b0;
  bit            m_wr    = 1'b0;
  logic [W-1:0]  m_word  = '0;
  logic [NB-1:0] m_rx    = '0;
  int            m_t     = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act   = 1'b0;
      m_ready = 1'b0;
    end else if (!m_act) begin
      if (bus.cmd_valid && m_ready) begin
        m_act = 1'b1; m_ready = 1'b0; m_wr = bus.cmd_write;
        m_word = bus.cmd_data; m_t = 1; m_rx = '0;
      end else begin
        m_ready = 1'b1;
      end
    end else begin
      if (!m_wr && m_t <= NB * DIV && (m_t - 1) % DIV == DIV / 2)
        m_rx = {m_rx[NB-2:0], pad_i};
      if (m_t >= (m_wr ? NB * DIV + TURN + 1 : NB * DIV + 1) && bus.rsp_ready) begin
        m_act = 1'b0; m_ready = 1'b1;
      end else begin
        m_t++;
      end
    end
  end

  always @(negedge clk) begin
    logic e_rdy, e_busy, e_oe, e_o, e_v, e_err;
    logic [W-1:0]  e_d;
    logic [NB-1:0] txb;
    e_rdy = 0; e_busy = 0; e_oe = 0; e_o = 0; e_v = 0; e_err = 0; e_d = '0;
    txb = frame(m_word);
    if (rst) begin
      if (!m_act) begin
        e_rdy = m_ready;
      end else begin
        e_busy = 1'b1;
        if (m_wr && m_t <= NB * DIV) begin
          e_oe = 1'b1;
          e_o  = txb[NB - 1 - (m_t - 1) / DIV];
        end
        if (m_t >= (m_wr ? NB * DIV + TURN + 1 : NB * DIV + 1)) begin
          e_v   = 1'b1;
          e_d   = m_wr ? m_word : m_rx[NB-1 -: W];
          e_err = !m_wr && PAR && (^m_rx);
        end
      end
    end
    chk("cmd_ready", bus.cmd_ready, e_rdy);
    chk("busy", busy, e_busy);
    chk("pad_oe", pad_oe, e_oe);
    chk("pad_o", pad_o, e_o);
    chk("rsp_valid", bus.rsp_valid, e_v);
    chk("rsp_err", bus.rsp_err, e_err);
    if (e_v) chk("rsp_data", bus.rsp_data, e_d);
  end

  // Offer a command (called on a falling edge); returns once the accepting edge has passed.
  task automatic offer(input logic wr, input logic [W-1:0] d, output bit ok);
    int guard = 0;
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_data = d;
    while (bus.cmd_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    ok = (guard < 100);
    chk("accept_in_time", ok, 1);
    @(negedge clk);
  endtask

  task automatic run_cmd(input logic wr, input logic [W-1:0] d, input logic [NB-1:0] rxb,
                         input int hold, input bit keep,
                         output int rsp_cyc, output logic [W-1:0] rdat, output logic rerr,
                         output logic [NB-1:0] txseen, output int oe_cnt, output int val_cnt,
                         output int rdy_cyc);
    bit ok;
    rsp_cyc = -1; rdat = '0; rerr = 0; txseen = '0; oe_cnt = 0; val_cnt = 0; rdy_cyc = -1;
    bus.rsp_ready = (hold == 0);
    offer(wr, d, ok);
    bus.cmd_valid = keep;
    if (ok) begin
      for (int c = 1; c < 250; c++) begin
        if (!wr && c <= NB * DIV && (c - 1) % DIV == 0) pad_i = rxb[NB - 1 - (c - 1) / DIV];
        oe_cnt += int'(pad_oe);
        if (wr && c <= NB * DIV && (c - 1) % DIV == DIV / 2) txseen[NB - 1 - (c - 1) / DIV] = pad_o;
        if (bus.rsp_valid) begin
          if (rsp_cyc < 0) begin rsp_cyc = c; rdat = bus.rsp_data; rerr = bus.rsp_err; end
          if (bus.rsp_data == rdat) val_cnt++;
        end
        if (hold > 0 && rsp_cyc > 0 && c == rsp_cyc + hold) bus.rsp_ready = 1'b1;
        if (bus.cmd_ready) begin
          rdy_cyc = c;
          bus.cmd_valid = 1'b0;
          break;
        end
        @(negedge clk);
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("cmd_completed", rdy_cyc > 0, 1);
  endtask

  int rc, oc, vc, yc, cnt;
  logic [W-1:0] rd;
  logic re;
  logic [NB-1:0] ts;
  bit ok;

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_data = '0; bus.rsp_ready = 0; pad_i = 0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_pad_oe", pad_oe, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("ready_first_edge", bus.cmd_ready, 1);

    // Write 0xA5, response taken immediately
    run_cmd(1'b1, 8'hA5, '0, 0, 1'b0, rc, rd, re, ts, oc, vc, yc);
    chk("wr_a5_rsp_cycle", rc, 35 + PX);
    chk("wr_a5_rsp_data", rd, 8'hA5);
    chk("wr_a5_bits", ts[NB-1 -: W], 8'hA5);
    chk("wr_a5_oe_cycles", oc, 32 + PX);
    chk("wr_a5_ready_cycle", yc, 36 + PX);

    // Read 0x3C
    run_cmd(1'b0, '0, frame(8'h3C), 0, 1'b0, rc, rd, re, ts, oc, vc, yc);
    chk("rd_3c_rsp_cycle", rc, 33 + PX);
    chk("rd_3c_rsp_data", rd, 8'h3C);
    chk("rd_3c_oe_cycles", oc, 0);
    chk("rd_3c_err", re, 0);

    // Read 0xFF held off for 10 cycles
    run_cmd(1'b0, '0, frame(8'hFF), 10, 1'b0, rc, rd, re, ts, oc, vc, yc);
    chk("bp_rsp_data", rd, 8'hFF);
    chk("bp_stable_cycles", vc, 11);
    chk("bp_ready_cycle", yc, 44 + PX);

    // Read 0x5A with cmd_valid held high while busy
    run_cmd(1'b0, '0, frame(8'h5A), 0, 1'b1, rc, rd, re, ts, oc, vc, yc);
    chk("busy_rsp_data", rd, 8'h5A);
    chk("busy_ready_cycle", yc, 34 + PX);

    // Reset in the middle of writing 0x81
    bus.rsp_ready = 1'b1;
    offer(1'b1, 8'h81, ok);
    bus.cmd_valid = 1'b0;
    repeat (11) @(negedge clk);
    chk("midrst_pre_oe", pad_oe, 1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_oe", pad_oe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pad_o", pad_o, 0);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", bus.cmd_ready, 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) cnt++;
    end
    chk("midrst_no_rsp", cnt, 0);
    bus.rsp_ready = 1'b0;

    // Recovery: write 0x3C after the reset
    run_cmd(1'b1, 8'h3C, '0, 0, 1'b0, rc, rd, re, ts, oc, vc, yc);
    chk("post_rst_rsp_cycle", rc, 35 + PX);
    chk("post_rst_rsp_data", rd, 8'h3C);

`ifdef HALFDUPLEX_PARITY_EN
    run_cmd(1'b1, 8'h07, '0, 0, 1'b0, rc, rd, re, ts, oc, vc, yc);
    chk("par_wr_rsp_cycle", rc, 39);
    chk("par_wr_bits", ts, 9'h00F);
    run_cmd(1'b0, '0, 9'h00E, 0, 1'b0, rc, rd, re, ts, oc, vc, yc);
    chk("par_rd_data", rd, 8'h07);
    chk("par_rd_err", re, 1);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
